game_state_ctrl: RTL and testbench

- Top-level game sequencer for Stickman Run.
- Produces the one-hot status vector {waiting, playing, win, lose} that drives the color mapper's screen selection.
- Gates and restarts the sprite and coin logic, and keeps score (coins) and distance (frames survived).
- Sits between the keyboard keycode path, the collision/coin detectors and color_mapper; advances once per frame_clk (VGA_VS) rising edge.

---
 rtl/game_state_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_state_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: top-level game sequencer for Stickman Run.
// Steps once per frame (rising edge of frame_clk / VGA_VS). It gates sprite
// motion, sends the restart pulse to sprites and coins, and keeps the coin
// score and the distance (frames survived) for the current round.
//
// Ports:
//   Clk           in   system clock
//   Reset         in   synchronous, active-high reset
//   frame_clk     in   VGA vertical sync; each rising edge is one frame
//   keycode       in   current USB keycode, 8'h00 = no key
//   coin_hit      in   level, high while the stickman overlaps a coin
//   stickman_dead in   level, high on fall/obstacle collision
//   status        out  one-hot {waiting, playing, win, lose}
//   run_en        out  high only while playing
//   restart       out  one-Clk pulse: sprites/coins reload start positions
//   score         out  coins collected this round
//   distance      out  frames survived this round
//
// state   | meaning
// PREWAIT | waiting for the keyboard to go idle (blocks a held start key)
// WAIT    | title screen, waiting for the start key
// PLAY    | round running
// WIN     | win screen, keyboard ignored until the hold time expires
// LOSE    | lose screen, keyboard ignored until the hold time expires
module game_state_ctrl #(
  parameter logic [7:0] START_KEY   = 8'h2C,
  parameter int         WIN_FRAMES  = 1800,
  parameter int         COIN_GOAL   = 20,
  parameter int         HOLD_FRAMES = 120,
  parameter int         SCORE_W     = 8,
  parameter int         DIST_W      = 12
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [7:0]         keycode,
  input  logic               coin_hit,
  input  logic               stickman_dead,
  output logic [3:0]         status,
  output logic               run_en,
  output logic               restart,
  output logic [SCORE_W-1:0] score,
  output logic [DIST_W-1:0]  distance
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [2:0] {
    PREWAIT = 3'd0,
    WAIT    = 3'd1,
    PLAY    = 3'd2,
    WIN     = 3'd3,
    LOSE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               frame_clk_q;
  logic               coin_q;
  logic               restart_q, restart_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [DIST_W-1:0]  distance_q, distance_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic frame_tick;
  logic coin_rise;
  logic score_goal;
  logic dist_goal;
  logic hold_done;

  assign frame_tick = frame_clk & ~frame_clk_q;
  assign coin_rise  = coin_hit & ~coin_q;

  // Compare in 32 bits so goals wider than the counters cannot alias.
  assign score_goal = {{(32-SCORE_W){1'b0}}, score_q} >= 32'(COIN_GOAL);
  assign dist_goal  = ({{(32-DIST_W){1'b0}}, distance_q} + 32'd1) == 32'(WIN_FRAMES);
  assign hold_done  = hold_cnt_q == HOLD_W'(HOLD_FRAMES);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= PREWAIT;
      frame_clk_q <= 1'b0;
      coin_q      <= 1'b0;
      restart_q   <= 1'b0;
      score_q     <= '0;
      distance_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      frame_clk_q <= frame_clk;
      coin_q      <= coin_hit;
      restart_q   <= restart_d;
      score_q     <= score_d;
      distance_q  <= distance_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    restart_d  = 1'b0;
    score_d    = score_q;
    distance_d = distance_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      PREWAIT: begin
        if (frame_tick && keycode == 8'h00) state_d = WAIT;
      end
      WAIT: begin
        if (frame_tick && keycode == START_KEY) begin
          state_d    = PLAY;
          restart_d  = 1'b1;
          score_d    = '0;
          distance_d = '0;
        end
      end
      PLAY: begin
        if (coin_rise && score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
        if (frame_tick) begin
          if (stickman_dead) begin
            state_d    = LOSE;
            hold_cnt_d = '0;
          end else begin
            if (distance_q != {DIST_W{1'b1}}) distance_d = distance_q + DIST_W'(1);
            // Win check uses the pre-increment score: a coin landing on this
            // same tick wins on the following tick.
            if (score_goal || dist_goal) begin
              state_d    = WIN;
              hold_cnt_d = '0;
            end
          end
        end
      end
      WIN, LOSE: begin
        if (frame_tick) begin
          if (hold_done && keycode == START_KEY) state_d = PREWAIT;
          else if (!hold_done) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = PREWAIT;
    endcase
  end

  // Decoded straight from the state register; any illegal encoding shows the
  // waiting screen so status stays one-hot.
  always_comb begin
    status = 4'b1000;
    case (state_q)
      PLAY:    status = 4'b0100;
      WIN:     status = 4'b0010;
      LOSE:    status = 4'b0001;
      default: status = 4'b1000;
    endcase
  end

  assign run_en   = state_q == PLAY;
  assign restart  = restart_q;
  assign score    = score_q;
  assign distance = distance_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic        coin_hit;
  logic        stickman_dead;

  // u_dut: short round (WIN_FRAMES = 5); u_long: default parameters.
  logic [3:0]  status_s, status_l;
  logic        run_en_s, run_en_l;
  logic        restart_s, restart_l;
  logic [7:0]  score_s, score_l;
  logic [11:0] distance_s, distance_l;

  int tests = 0;
  int fails = 0;

  game_state_ctrl #(.WIN_FRAMES(5)) u_dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .coin_hit(coin_hit), .stickman_dead(stickman_dead),
    .status(status_s), .run_en(run_en_s), .restart(restart_s),
    .score(score_s), .distance(distance_s)
  );

  game_state_ctrl u_long (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .coin_hit(coin_hit), .stickman_dead(stickman_dead),
    .status(status_l), .run_en(run_en_l), .restart(restart_l),
    .score(score_l), .distance(distance_l)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_edge();
    @(negedge Clk); frame_clk = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic tick_low();
    @(negedge Clk); frame_clk = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic tick();
    tick_edge();
    tick_low();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic coin_pulse();
    @(negedge Clk); coin_hit = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk); coin_hit = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; coin_hit = 1'b0; stickman_dead = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic to_play();
    keycode = 8'h00;
    do_reset();
    tick();
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
  endtask

  task automatic test_reset();
    keycode = 8'h00;
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; coin_hit = 1'b0; stickman_dead = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    tests++;
    if (status_s !== 4'b1000 || run_en_s !== 1'b0 || restart_s !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got status=%b run_en=%b restart=%b want 1000/0/0", status_s, run_en_s, restart_s);
    end
    tests++;
    if (score_s !== 8'd0 || distance_s !== 12'd0) begin
      fails++;
      $display("FAIL reset_counters got score=%0d distance=%0d want 0/0", score_s, distance_s);
    end
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    tests++;
    if (status_s !== 4'b1000 || restart_s !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got status=%b restart=%b want 1000/0", status_s, restart_s);
    end
    // coin outside PLAY is ignored
    coin_pulse();
    tests++;
    if (score_l !== 8'd0) begin
      fails++;
      $display("FAIL coin_ignored_prewait got score=%0d want 0", score_l);
    end
    ticks(3);
    tests++;
    if (status_s !== 4'b1000 || run_en_s !== 1'b0) begin
      fails++;
      $display("FAIL wait_holds got status=%b run_en=%b want 1000/0", status_s, run_en_s);
    end
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    tests++;
    if (status_s !== 4'b0100 || run_en_s !== 1'b1) begin
      fails++;
      $display("FAIL wait_to_play got status=%b run_en=%b want 0100/1", status_s, run_en_s);
    end
  endtask

  task automatic test_start_key();
    keycode = 8'h2C;
    do_reset();
    ticks(3);
    tests++;
    if (status_s !== 4'b1000) begin
      fails++;
      $display("FAIL held_key_blocked got status=%b want 1000", status_s);
    end
    keycode = 8'h00;
    tick();
    keycode = 8'h2C;
    tick_edge();
    tests++;
    if (status_s !== 4'b0100 || restart_s !== 1'b1 || score_s !== 8'd0) begin
      fails++;
      $display("FAIL start_play got status=%b restart=%b score=%0d want 0100/1/0", status_s, restart_s, score_s);
    end
    @(posedge Clk); #1;
    tests++;
    if (restart_s !== 1'b0) begin
      fails++;
      $display("FAIL restart_width got restart=%b want 0", restart_s);
    end
    tick_low();
    keycode = 8'h00;
  endtask

  task automatic test_coins();
    to_play();
    coin_pulse();
    coin_pulse();
    coin_pulse();
    tests++;
    if (score_l !== 8'd3) begin
      fails++;
      $display("FAIL coin_pulses got score=%0d want 3", score_l);
    end
    @(negedge Clk); coin_hit = 1'b1;
    ticks(10);
    @(negedge Clk); coin_hit = 1'b0;
    @(posedge Clk); #1;
    tests++;
    if (score_l !== 8'd4 || distance_l !== 12'd10 || status_l !== 4'b0100) begin
      fails++;
      $display("FAIL coin_held got score=%0d distance=%0d status=%b want 4/10/0100", score_l, distance_l, status_l);
    end
  endtask

  task automatic test_coin_goal();
    to_play();
    for (int i = 0; i < 19; i++) coin_pulse();
    // goal-reaching coin on the same Clk as a frame tick
    @(negedge Clk); coin_hit = 1'b1; frame_clk = 1'b1;
    @(posedge Clk); #1;
    tests++;
    if (score_l !== 8'd20 || status_l !== 4'b0100) begin
      fails++;
      $display("FAIL coin_on_tick got score=%0d status=%b want 20/0100", score_l, status_l);
    end
    @(negedge Clk); coin_hit = 1'b0; frame_clk = 1'b0;
    @(posedge Clk); #1;
    tick();
    tests++;
    if (status_l !== 4'b0010 || run_en_l !== 1'b0 || distance_l !== 12'd2) begin
      fails++;
      $display("FAIL coin_win got status=%b run_en=%b distance=%0d want 0010/0/2", status_l, run_en_l, distance_l);
    end
  endtask

  task automatic test_win_frames();
    to_play();
    ticks(4);
    tests++;
    if (status_s !== 4'b0100 || distance_s !== 12'd4) begin
      fails++;
      $display("FAIL before_win got status=%b distance=%0d want 0100/4", status_s, distance_s);
    end
    tick();
    tests++;
    if (status_s !== 4'b0010 || distance_s !== 12'd5 || run_en_s !== 1'b0) begin
      fails++;
      $display("FAIL frame_win got status=%b distance=%0d run_en=%b want 0010/5/0", status_s, distance_s, run_en_s);
    end
    tests++;
    if (status_l !== 4'b0100 || distance_l !== 12'd5) begin
      fails++;
      $display("FAIL long_still_play got status=%b distance=%0d want 0100/5", status_l, distance_l);
    end
  endtask

  task automatic test_death_and_hold();
    to_play();
    ticks(4);
    stickman_dead = 1'b1;
    tick();
    stickman_dead = 1'b0;
    tests++;
    if (status_s !== 4'b0001 || distance_s !== 12'd4 || run_en_s !== 1'b0) begin
      fails++;
      $display("FAIL death_priority got status=%b distance=%0d run_en=%b want 0001/4/0", status_s, distance_s, run_en_s);
    end
    ticks(50);
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    tests++;
    if (status_s !== 4'b0001) begin
      fails++;
      $display("FAIL hold_50_ignored got status=%b want 0001", status_s);
    end
    ticks(68);
    keycode = 8'h2C;
    tick();
    tests++;
    if (status_s !== 4'b0001 || distance_s !== 12'd4) begin
      fails++;
      $display("FAIL hold_119_ignored got status=%b distance=%0d want 0001/4", status_s, distance_s);
    end
    tick();
    tests++;
    if (status_s !== 4'b1000) begin
      fails++;
      $display("FAIL hold_done_exit got status=%b want 1000", status_s);
    end
    tick();
    tests++;
    if (status_s !== 4'b1000) begin
      fails++;
      $display("FAIL prewait_blocks_key got status=%b want 1000", status_s);
    end
    keycode = 8'h00;
  endtask

  task automatic test_reset_mid_play();
    to_play();
    coin_pulse();
    ticks(2);
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    tests++;
    if (status_l !== 4'b1000 || score_l !== 8'd0 || distance_l !== 12'd0 || run_en_l !== 1'b0 || restart_l !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_play got status=%b score=%0d distance=%0d run_en=%b restart=%b want 1000/0/0/0/0",
               status_l, score_l, distance_l, run_en_l, restart_l);
    end
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'h00;
    coin_hit = 1'b0;
    stickman_dead = 1'b0;
    test_reset();
    test_start_key();
    test_coins();
    test_coin_goal();
    test_win_frames();
    test_death_and_hold();
    test_reset_mid_play();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
